a2_pipe_stage: RTL and testbench

//  Generic elastic pipeline register between adjacent datapath stages (EX/WB, ID/EX, ...).

---
 rtl/a2_pipe_pkg.sv | 27 ++
 rtl/a2_pipe_slot.sv | 34 +++
 rtl/a2_pipe_stage.sv | 162 ++++++++++++++++
 tb/tb_a2_pipe_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/a2_pipe_pkg.sv
// a2_pipe_pkg: shared state encodings and default widths for the a2 pipeline stage.
package a2_pipe_pkg;

  // Default widths (one lane = DATA_W bits, NUM_DATA lanes).
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_NUM_DATA = 2;
  localparam int DEF_RD_W     = 3;
  localparam int DEF_CTRL_W   = 2;
  localparam int DEF_WREN_BIT = 0;

  // Stage state; the value equals the number of entries held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  // Occupancy implied by a state encoding (illegal encodings report 0).
  function automatic logic [1:0] occ_of(input state_e s);
    case (s)
      ST_FULL: occ_of = 2'd1;
      ST_SKID: occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/a2_pipe_slot.sv
// a2_pipe_slot: one payload register {ctrl,rd,data} with synchronous load and clear.
// Clear wins over load; reset zeroes the slot.
module a2_pipe_slot
  import a2_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] slot_q;
  logic [W-1:0] slot_d;

  // Next slot value: clear beats load, otherwise hold.
  always_comb begin
    slot_d = slot_q;
    if (clear)     slot_d = '0;
    else if (load) slot_d = d;
  end

  // Slot register.
  always_ff @(posedge clk) begin
    if (reset) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  assign q = slot_q;

endmodule

// File: rtl/a2_pipe_stage.sv
// a2_pipe_stage: elastic pipeline register with a 2-entry skid buffer, flush and occupancy.
// Optional forwarding comparator enabled by defining PIPE_STAGE_FWD_EN.
//
// Handshake: a beat moves on an interface when valid & ready are both high at the
// rising edge; valid/payload are held stable by the source until accepted. in_ready
// and occupancy are functions of the state register only. flush drops any beat
// offered in the same cycle even though in_ready may read 1.
module a2_pipe_stage
  import a2_pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_DATA = DEF_NUM_DATA,
  parameter int RD_W     = DEF_RD_W,
  parameter int CTRL_W   = DEF_CTRL_W,
  parameter int WREN_BIT = DEF_WREN_BIT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [RD_W-1:0]            in_rd,
  input  logic [NUM_DATA*DATA_W-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [RD_W-1:0]            out_rd,
  output logic [NUM_DATA*DATA_W-1:0] out_data,
  output logic [1:0]                 occupancy,
`ifdef PIPE_STAGE_FWD_EN
  input  logic [RD_W-1:0]            fwd_rs,
  output logic                       fwd_hit,
  output logic [NUM_DATA*DATA_W-1:0] fwd_data,
`endif
  output logic [1:0]                 dbg_state
);

  localparam int DW     = NUM_DATA * DATA_W;
  localparam int SLOT_W = CTRL_W + RD_W + DW;

  // Catch a write-enable index outside the control field at elaboration.
  if (WREN_BIT < 0 || WREN_BIT >= CTRL_W) begin : g_bad_wren_bit
    $error("a2_pipe_stage: WREN_BIT out of range");
  end

  state_e state_q;
  state_e state_d;

  logic              acc;
  logic              drn;
  logic              main_load;
  logic              main_clr;
  logic              main_from_skid;
  logic              skid_load;
  logic              skid_clr;
  logic [SLOT_W-1:0] in_payload;
  logic [SLOT_W-1:0] main_d;
  logic [SLOT_W-1:0] main_q;
  logic [SLOT_W-1:0] skid_q;

  assign in_payload = {in_ctrl, in_rd, in_data};
  assign main_d     = main_from_skid ? skid_q : in_payload;

  // Outputs decoded from the state register alone; illegal encodings look empty and stalled.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_EMPTY: in_ready = 1'b1;
      ST_FULL: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
      end
      ST_SKID: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;
  assign occupancy = occ_of(state_q);
  assign dbg_state = state_q;

  // Next state and slot controls; flush overrides the handshake.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (acc) begin
            state_d   = ST_FULL;
            main_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (acc && drn) begin
            main_load = 1'b1;
          end else if (acc) begin
            state_d   = ST_SKID;
            skid_load = 1'b1;
          end else if (drn) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (drn) begin
            state_d        = ST_FULL;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  a2_pipe_slot #(.W(SLOT_W)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_d),
    .q     (main_q)
  );

  a2_pipe_slot #(.W(SLOT_W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clr),
    .d     (in_payload),
    .q     (skid_q)
  );

  assign {out_ctrl, out_rd, out_data} = main_q;

`ifdef PIPE_STAGE_FWD_EN
  // Forwarding match against the register this stage is about to write.
  always_comb begin
    fwd_hit  = out_valid & out_ctrl[WREN_BIT] & (out_rd == fwd_rs) & (fwd_rs != '0);
    fwd_data = fwd_hit ? out_data : '0;
  end
`endif

endmodule

// File: tb/tb_a2_pipe_stage.sv
// tb_a2_pipe_stage: directed bench for a2_pipe_stage (forwarding checks when PIPE_STAGE_FWD_EN is defined).
module tb_a2_pipe_stage;

  localparam int PW = 2 + 3 + 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_ctrl;
  logic [2:0]  in_rd;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_ctrl;
  logic [2:0]  out_rd;
  logic [15:0] out_data;
  logic [1:0]  occupancy;
  logic [1:0]  dbg_state;
`ifdef PIPE_STAGE_FWD_EN
  logic [2:0]  fwd_rs;
  logic        fwd_hit;
  logic [15:0] fwd_data;
`endif

  int total = 0;
  int bad   = 0;
  logic [PW-1:0] exp_q[$];

  // Clock.
  always #5 clk = ~clk;

  a2_pipe_stage dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_rd     (in_rd),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_rd    (out_rd),
    .out_data  (out_data),
    .occupancy (occupancy),
`ifdef PIPE_STAGE_FWD_EN
    .fwd_rs    (fwd_rs),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
`endif
    .dbg_state (dbg_state)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] c, input logic [2:0] r, input logic [15:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_rd    = r;
    in_data  = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 2'b00, 3'd0, 16'h0000);
    step(); step();
    reset = 1'b0;
    drive(1'b1, 2'b11, 3'd5, 16'hCDAB);
    step(); step();
    drive(1'b0, 2'b00, 3'd0, 16'h0000);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0h exp=0", out_valid); end
    total++; if (out_ctrl !== 2'b00) begin bad++; $display("FAIL reset_out_ctrl got=%0h exp=0", out_ctrl); end
    total++; if (out_rd !== 3'd0) begin bad++; $display("FAIL reset_out_rd got=%0h exp=0", out_rd); end
    total++; if (out_data !== 16'h0000) begin bad++; $display("FAIL reset_out_data got=%0h exp=0", out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0h exp=1", in_ready); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_pass_through();
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 3'd1, 16'h2010);
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pass_a_valid got=%0h exp=1", out_valid); end
    total++; if ({out_rd, out_data} !== {3'd1, 16'h2010}) begin bad++; $display("FAIL pass_a_payload got=%0h/%0h exp=1/2010", out_rd, out_data); end
    total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL pass_a_occ got=%0d exp=1", occupancy); end
    drive(1'b1, 2'b01, 3'd2, 16'h4030);
    step();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL pass_b_valid got=%0h exp=1", out_valid); end
    total++; if ({out_rd, out_data} !== {3'd2, 16'h4030}) begin bad++; $display("FAIL pass_b_payload got=%0h/%0h exp=2/4030", out_rd, out_data); end
    total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL pass_b_occ got=%0d exp=1", occupancy); end
    drive(1'b0, 2'b00, 3'd0, 16'h0000);
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pass_drain_valid got=%0h exp=0", out_valid); end
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL pass_drain_occ got=%0d exp=0", occupancy); end
    total++; if ({out_rd, out_data} !== {3'd2, 16'h4030}) begin bad++; $display("FAIL pass_hold_payload got=%0h/%0h exp=2/4030", out_rd, out_data); end
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 3'd1, 16'h0A0A);
    step();
    drive(1'b1, 2'b01, 3'd2, 16'h0B0B);
    step();
    drive(1'b0, 2'b00, 3'd0, 16'h0000);
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL skid_occ got=%0d exp=2", occupancy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL skid_in_ready got=%0h exp=0", in_ready); end
    total++; if ({out_valid, out_rd, out_data} !== {1'b1, 3'd1, 16'h0A0A}) begin bad++; $display("FAIL skid_head_a got=%0h/%0h/%0h exp=1/1/a0a", out_valid, out_rd, out_data); end
    step();
    total++; if ({out_valid, out_rd, out_data} !== {1'b1, 3'd1, 16'h0A0A}) begin bad++; $display("FAIL skid_hold_a got=%0h/%0h/%0h exp=1/1/a0a", out_valid, out_rd, out_data); end
    out_ready = 1'b1;
    step();
    total++; if ({out_valid, out_rd, out_data} !== {1'b1, 3'd2, 16'h0B0B}) begin bad++; $display("FAIL skid_head_b got=%0h/%0h/%0h exp=1/2/b0b", out_valid, out_rd, out_data); end
    total++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL skid_after_a occ=%0d rdy=%0h exp occ=1 rdy=1", occupancy, in_ready); end
    step();
    total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL skid_empty valid=%0h occ=%0d exp valid=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 3'd3, 16'h1111);
    step();
    drive(1'b1, 2'b01, 3'd4, 16'h2222);
    step();
    total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL flush_pre_occ got=%0d exp=2", occupancy); end
    flush = 1'b1;
    drive(1'b1, 2'b11, 3'd7, 16'h7777);
    step();
    flush = 1'b0;
    drive(1'b0, 2'b00, 3'd0, 16'h0000);
    total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0h exp=0", out_valid); end
    total++; if ({out_ctrl, out_rd, out_data} !== {2'b00, 3'd0, 16'h0000}) begin bad++; $display("FAIL flush_payload got=%0h/%0h/%0h exp=0/0/0", out_ctrl, out_rd, out_data); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%0h exp=1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped_item cycle=%0d valid=%0h rd=%0h exp valid=0", i, out_valid, out_rd); end
    end
  endtask

  task automatic test_back_to_back();
    logic [PW-1:0] item;
    logic [PW-1:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < 21; i++) begin
      item = PW'($urandom_range(0, (1 << PW) - 1));
      drive(1'b1, item[20:19], item[18:16], item[15:0]);
      exp_q.push_back(item);
      step();
      total++; if (exp_q.size() == 0) begin bad++; $display("FAIL stream_queue_empty cycle=%0d", i); end
      else begin
        exp = exp_q.pop_front();
        if ({out_valid, out_ctrl, out_rd, out_data} !== {1'b1, exp}) begin
          bad++; $display("FAIL stream_item cycle=%0d got=%0h/%0h exp=1/%0h", i, out_valid, {out_ctrl, out_rd, out_data}, exp);
        end
      end
      total++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL stream_stall cycle=%0d occ=%0d rdy=%0h exp occ=1 rdy=1", i, occupancy, in_ready); end
    end
    drive(1'b0, 2'b00, 3'd0, 16'h0000);
    step();
    total++; if (out_valid !== 1'b0 || exp_q.size() != 0) begin bad++; $display("FAIL stream_tail valid=%0h left=%0d exp valid=0 left=0", out_valid, exp_q.size()); end
  endtask

`ifdef PIPE_STAGE_FWD_EN
  task automatic test_forward();
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 3'd3, 16'h6655);
    step();
    drive(1'b0, 2'b00, 3'd0, 16'h0000);
    fwd_rs = 3'd3; #1;
    total++; if (fwd_hit !== 1'b1 || fwd_data !== 16'h6655) begin bad++; $display("FAIL fwd_hit got=%0h/%0h exp=1/6655", fwd_hit, fwd_data); end
    fwd_rs = 3'd2; #1;
    total++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0000) begin bad++; $display("FAIL fwd_other_rs got=%0h/%0h exp=0/0", fwd_hit, fwd_data); end
    fwd_rs = 3'd0; #1;
    total++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0000) begin bad++; $display("FAIL fwd_rs_zero got=%0h/%0h exp=0/0", fwd_hit, fwd_data); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b1, 2'b10, 3'd3, 16'h6655);
    step();
    drive(1'b0, 2'b00, 3'd0, 16'h0000);
    fwd_rs = 3'd3; #1;
    total++; if (fwd_hit !== 1'b0 || fwd_data !== 16'h0000) begin bad++; $display("FAIL fwd_no_wren got=%0h/%0h exp=0/0", fwd_hit, fwd_data); end
    fwd_rs = 3'd0;
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask
`endif

  initial begin
`ifdef PIPE_STAGE_FWD_EN
    fwd_rs = 3'd0;
`endif
    test_reset();
    test_pass_through();
    test_skid();
    test_flush();
    test_back_to_back();
`ifdef PIPE_STAGE_FWD_EN
    test_forward();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
